// File: rtl/fifo_rd_arbiter.sv
// Round-robin burst read scheduler for NUM_CH synchronous FIFOs feeding one
// valid/ready stream port through a 2-entry tagged output buffer.
module fifo_rd_arbiter #(
  parameter int NUM_CH      = 4,
  parameter int DATA_WIDTH  = 16,
  parameter int LEVEL_WIDTH = 10,
  parameter int BURST_LEN   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [NUM_CH-1:0]             ch_rempty,
  input  logic [NUM_CH*LEVEL_WIDTH-1:0] ch_level,
  output logic [NUM_CH-1:0]             ch_r_en,
  input  logic [NUM_CH*DATA_WIDTH-1:0]  ch_rdata,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [DATA_WIDTH-1:0]         m_data,
  output logic [$clog2(NUM_CH)-1:0]     m_ch,
  output logic                          m_last,
  output logic                          busy,
  output logic                          fsm_state
);

  // Handshake: a word moves downstream in every cycle where m_valid && m_ready
  // are both high at the rising edge; m_valid never depends on m_ready.
  localparam int CW = $clog2(NUM_CH);
  localparam int EW = DATA_WIDTH + CW + 1;

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t                 state, state_nx;
  logic [CW-1:0]          gnt, gnt_nx, last_gnt, last_gnt_nx;
  logic [LEVEL_WIDTH-1:0] cnt, cnt_nx, cnt_load;
  logic [LEVEL_WIDTH-1:0] level [NUM_CH];
  logic [DATA_WIDTH-1:0]  rdata [NUM_CH];
  logic [NUM_CH-1:0]      eligible;
  logic                   found;
  logic [CW-1:0]          pick, cand;
  int                     rr_idx;
  logic [1:0]             occ;
  logic                   inflight, pop, issue;
  logic [CW-1:0]          rd_ch;
  logic                   rd_last;
  logic [EW-1:0]          ent0, ent1, new_ent;

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      level[k]    = ch_level[k*LEVEL_WIDTH +: LEVEL_WIDTH];
      rdata[k]    = ch_rdata[k*DATA_WIDTH +: DATA_WIDTH];
      eligible[k] = !ch_rempty[k] && (level[k] != '0);
    end
  end

  // First eligible channel strictly after the previous grant, wrapping.
  always_comb begin
    found  = 1'b0;
    pick   = '0;
    cand   = '0;
    rr_idx = 0;
    for (int i = 1; i <= NUM_CH; i++) begin
      rr_idx = (int'(last_gnt) + i) % NUM_CH;
      cand   = CW'(rr_idx);
      if (!found && eligible[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign cnt_load = (level[pick] > LEVEL_WIDTH'(BURST_LEN)) ? LEVEL_WIDTH'(BURST_LEN)
                                                           : level[pick];

  assign m_valid = (occ != 2'd0);
  assign pop     = m_valid && m_ready;
  // A read may go out only if its word is guaranteed a buffer slot next cycle.
  assign issue   = (state == BURST) &&
                   (({1'b0, occ} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));

  always_comb begin
    ch_r_en = '0;
    if (issue) ch_r_en[gnt] = 1'b1;
  end

  always_comb begin
    state_nx    = state;
    gnt_nx      = gnt;
    last_gnt_nx = last_gnt;
    cnt_nx      = cnt;
    case (state)
      IDLE: begin
        if (enable && found) begin
          gnt_nx      = pick;
          last_gnt_nx = pick;
          cnt_nx      = cnt_load;
          state_nx    = BURST;
        end
      end
      BURST: begin
        if (issue) begin
          cnt_nx = cnt - LEVEL_WIDTH'(1);
          if (cnt == LEVEL_WIDTH'(1)) state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      last_gnt <= CW'(NUM_CH - 1);
      cnt      <= '0;
      inflight <= 1'b0;
      rd_ch    <= '0;
      rd_last  <= 1'b0;
    end else begin
      state    <= state_nx;
      gnt      <= gnt_nx;
      last_gnt <= last_gnt_nx;
      cnt      <= cnt_nx;
      inflight <= issue;
      if (issue) begin
        rd_ch   <= gnt;
        rd_last <= (cnt == LEVEL_WIDTH'(1));
      end
    end
  end

  // ent0 is always the head; a push lands in the first free slot.
  assign new_ent = {rd_last, rd_ch, rdata[rd_ch]};

  always_ff @(posedge clk) begin
    if (rst) begin
      occ  <= 2'd0;
      ent0 <= '0;
      ent1 <= '0;
    end else begin
      case ({inflight, pop})
        2'b10: begin
          if (occ == 2'd0) ent0 <= new_ent;
          else             ent1 <= new_ent;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          ent0 <= ent1;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            ent0 <= new_ent;
          end else begin
            ent0 <= ent1;
            ent1 <= new_ent;
          end
        end
        default: ;
      endcase
    end
  end

  assign {m_last, m_ch, m_data} = ent0;
  assign busy      = (state != IDLE) || inflight || (occ != 2'd0);
  assign fsm_state = (state == BURST);

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Randomized scoreboard bench for fifo_rd_arbiter with behavioural FIFOs and a
// transaction-level round-robin burst model.
module tb_fifo_rd_arbiter;

  localparam int NUM_CH = 4;
  localparam int DW     = 16;
  localparam int LW     = 10;
  localparam int BL     = 16;
  localparam int CW     = $clog2(NUM_CH);
  localparam int EW     = DW + CW + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              enable;
  logic [NUM_CH-1:0] ch_rempty;
  logic [NUM_CH*LW-1:0] ch_level;
  logic [NUM_CH-1:0] ch_r_en;
  logic [NUM_CH*DW-1:0] ch_rdata;
  logic              m_valid;
  logic              m_ready = 1'b1;
  logic [DW-1:0]     m_data;
  logic [CW-1:0]     m_ch;
  logic              m_last;
  logic              busy;
  logic              fsm_state;

  fifo_rd_arbiter #(
    .NUM_CH(NUM_CH), .DATA_WIDTH(DW), .LEVEL_WIDTH(LW), .BURST_LEN(BL)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .ch_rempty(ch_rempty),
    .ch_level(ch_level), .ch_r_en(ch_r_en), .ch_rdata(ch_rdata),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_ch(m_ch),
    .m_last(m_last), .busy(busy), .fsm_state(fsm_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- shared state ----------------
  logic [DW-1:0]     fq[NUM_CH][$];
  logic [NUM_CH-1:0] mask_empty = '0;
  logic [NUM_CH-1:0] mask_zero  = '0;
  logic [EW-1:0]     exp_q[$];
  int                n_tests = 0;
  int                n_fail  = 0;
  int                rdy_mode = 0;
  int                model_last = NUM_CH - 1;
  int                total_pops = 0;
  int                issued = 0;
  int                popped = 0;
  int                rd_total, first_rd, last_rd;
  int                rd_ch_cnt[NUM_CH];
  logic [NUM_CH-1:0] first_vec;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // ---------------- behavioural sync FIFOs ----------------
  always @(posedge clk) begin
    for (int k = 0; k < NUM_CH; k++) begin
      logic [DW-1:0] w;
      if (ch_r_en[k] && fq[k].size() > 0) begin
        w = fq[k].pop_front();
        ch_rdata[k*DW +: DW] <= w;
      end
      ch_rempty[k]         <= (fq[k].size() == 0) || mask_empty[k];
      ch_level[k*LW +: LW] <= mask_zero[k] ? '0 : LW'(fq[k].size());
    end
  end

  // ---------------- downstream ready pattern ----------------
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = ~m_ready;
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst) begin
      issued = 0;
      popped = 0;
    end else begin
      check("ren_onehot", 64'($countones(ch_r_en) <= 1), 1);
      check("masked_read", 64'(ch_r_en & (mask_empty | mask_zero)), 0);
      if (|ch_r_en) issued++;
      if (m_valid && m_ready) begin
        popped++;
        total_pops++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_word: got %0h expected none", {m_last, m_ch, m_data});
        end else begin
          check("word", 64'({m_last, m_ch, m_data}), 64'(exp_q.pop_front()));
        end
      end
      check("outstanding_le2", 64'((issued - popped) <= 2), 1);
    end
  end

  // ---------------- reference model ----------------
  // Replays round-robin bursts over a snapshot of the FIFO contents.
  task automatic model_run(input int max_bursts);
    logic [DW-1:0] mq[NUM_CH][$];
    int c, n, bursts;
    logic hit;
    logic [DW-1:0] w;
    for (int k = 0; k < NUM_CH; k++) mq[k] = fq[k];
    bursts = 0;
    forever begin
      hit = 1'b0;
      c = 0;
      for (int i = 1; i <= NUM_CH; i++) begin
        int cc;
        cc = (model_last + i) % NUM_CH;
        if (!hit && mq[cc].size() > 0 && !mask_empty[cc] && !mask_zero[cc]) begin
          hit = 1'b1;
          c = cc;
        end
      end
      if (!hit) break;
      n = (mq[c].size() > BL) ? BL : mq[c].size();
      for (int j = 0; j < n; j++) begin
        w = mq[c].pop_front();
        exp_q.push_back({1'(j == n - 1), CW'(c), w});
      end
      model_last = c;
      bursts++;
      if (max_bursts > 0 && bursts >= max_bursts) break;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input int ch, input int n);
    for (int i = 0; i < n; i++) fq[ch].push_back(DW'($urandom));
  endtask

  task automatic drain(input int budget);
    int cyc;
    cyc = 0; rd_total = 0; first_rd = -1; last_rd = -1; first_vec = '0;
    for (int k = 0; k < NUM_CH; k++) rd_ch_cnt[k] = 0;
    while ((exp_q.size() != 0 || busy) && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (|ch_r_en) begin
        if (first_rd < 0) begin
          first_rd  = cyc;
          first_vec = ch_r_en;
        end
        last_rd = cyc;
        rd_total++;
        for (int k = 0; k < NUM_CH; k++) if (ch_r_en[k]) rd_ch_cnt[k]++;
      end
    end
    check("drain_done", 64'(exp_q.size() == 0 && !busy), 1);
    step(1);
  endtask

  task automatic idle_check(input string name, input int n);
    int bad;
    bad = 0;
    repeat (n) begin
      @(negedge clk);
      if (|ch_r_en || busy || fsm_state) bad++;
    end
    check(name, 64'(bad), 0);
    step(1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n3, cyc, base;
    rst = 1'b1;
    enable = 1'b0;
    step(3);
    check("rst_ren", 64'(ch_r_en), 0);
    check("rst_mvalid", 64'(m_valid), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_state", 64'(fsm_state), 0);
    rst = 1'b0;
    step(2);

    // Single-channel burst with grant-to-output latency.
    load(2, 5);
    step(2);
    model_run(0);
    enable = 1'b1;
    @(negedge clk); check("t1_ren_T0", 64'(ch_r_en), 0);
    @(negedge clk); check("t1_ren_T1", 64'(ch_r_en), 64'b0100);
                    check("t1_state_T1", 64'(fsm_state), 1);
    @(negedge clk); check("t1_mvalid_T2", 64'(m_valid), 0);
    @(negedge clk); check("t1_mvalid_T3", 64'(m_valid), 1);
                    check("t1_mch_T3", 64'(m_ch), 2);
    drain(200);
    idle_check("t1_idle_after", 5);

    // Burst cap, round robin, back-to-back throughput.
    enable = 1'b0;
    for (int k = 0; k < NUM_CH; k++) load(k, 40);
    step(2);
    model_run(0);
    enable = 1'b1;
    drain(2000);
    check("t2_reads", 64'(rd_total), 160);
    check("t2_span", 64'(last_rd - first_rd + 1), 160 + 11);
    for (int k = 0; k < NUM_CH; k++) check("t2_ch_reads", 64'(rd_ch_cnt[k]), 40);

    // Backpressure with toggling ready.
    enable = 1'b0;
    rdy_mode = 1;
    load(0, 8);
    step(2);
    model_run(0);
    enable = 1'b1;
    drain(500);
    check("t3_reads", 64'(rd_total), 8);

    // Enable drop after the third read of a 10-word burst.
    enable = 1'b0;
    rdy_mode = 2;
    load(1, 10);
    load(2, 10);
    step(2);
    model_run(1);
    enable = 1'b1;
    n3 = 0; cyc = 0;
    while (n3 < 3 && cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (|ch_r_en) n3++;
    end
    check("t4_three_reads", 64'(n3), 3);
    enable = 1'b0;
    drain(500);
    check("t4_reads_after_drop", 64'(rd_total), 7);
    idle_check("t4_no_grant_disabled", 20);
    model_run(0);
    enable = 1'b1;
    drain(500);
    check("t4_second_reads", 64'(rd_total), 10);
    check("t4_second_ch", 64'(first_vec), 64'b0100);

    // Empty-flagged and zero-level channels are never granted.
    enable = 1'b0;
    rdy_mode = 0;
    for (int k = 0; k < NUM_CH; k++) load(k, $urandom_range(1, 20));
    mask_empty[1] = 1'b1;
    mask_zero[3]  = 1'b1;
    step(2);
    model_run(0);
    enable = 1'b1;
    drain(1000);
    idle_check("t5_idle_ineligible", 10);
    enable = 1'b0;
    fq[1].delete();
    fq[3].delete();
    mask_empty = '0;
    mask_zero  = '0;
    step(2);

    // Reset during word 4 of a 12-word burst.
    load(0, 12);
    step(2);
    model_run(0);
    base = total_pops;
    enable = 1'b1;
    cyc = 0;
    while ((total_pops - base) < 3 && cyc < 100) begin
      step(1);
      cyc++;
    end
    check("t6_three_pops", 64'(total_pops - base), 3);
    rst = 1'b1;
    enable = 1'b0;
    exp_q.delete();
    step(1);
    check("t6_ren", 64'(ch_r_en), 0);
    check("t6_mvalid", 64'(m_valid), 0);
    check("t6_mdata", 64'(m_data), 0);
    check("t6_mch", 64'(m_ch), 0);
    check("t6_mlast", 64'(m_last), 0);
    check("t6_busy", 64'(busy), 0);
    check("t6_state", 64'(fsm_state), 0);
    rst = 1'b0;
    for (int k = 0; k < NUM_CH; k++) fq[k].delete();
    model_last = NUM_CH - 1;
    step(2);
    load(1, 6);
    load(3, 6);
    step(2);
    model_run(0);
    enable = 1'b1;
    drain(500);
    check("t6_first_grant", 64'(first_vec), 64'b0010);

    // Randomized rounds.
    for (int r = 0; r < 8; r++) begin
      enable = 1'b0;
      rdy_mode = $urandom_range(0, 2);
      for (int k = 0; k < NUM_CH; k++) begin
        load(k, $urandom_range(0, 40));
        mask_empty[k] = ($urandom_range(0, 5) == 0);
        mask_zero[k]  = ($urandom_range(0, 5) == 0);
      end
      step(2);
      model_run(0);
      enable = 1'b1;
      drain(4000);
      enable = 1'b0;
      for (int k = 0; k < NUM_CH; k++) fq[k].delete();
      mask_empty = '0;
      mask_zero  = '0;
      step(2);
    end

    check("final_exp_empty", 64'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
